// File: rtl/output_layer_pkg.sv
// Shared types and constants for the output-layer multiply-accumulate engine.
package output_layer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_STORE,
    S_DONE
  } state_t;

  localparam int ACC_W_DEF = 20;
  localparam int SHIFT_DEF = 7;
  localparam int NODE_W    = 4;
  localparam int IDX_W     = 4;

  // A 4-bit count field uses 0 to mean a full 16.
  function automatic logic [4:0] decode_count(input logic [3:0] c);
    return (c == 4'd0) ? 5'd16 : {1'b0, c};
  endfunction

endpackage

// File: rtl/mac_sat_unit.sv
// Scales an accumulated score by an arithmetic right shift (floor) and clamps it to signed 8-bit.
module mac_sat_unit #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [7:0]       sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = 127;
  localparam logic signed [ACC_W-1:0] MIN_V = -128;

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_i >>> SHIFT;
    if (shifted > MAX_V) begin
      sat_o = 8'sd127;
    end else if (shifted < MIN_V) begin
      sat_o = -8'sd128;
    end else begin
      sat_o = shifted[7:0];
    end
  end

endmodule

// File: rtl/output_layer_mac.sv
// Output-layer MAC: N nodes x M inputs against an external 1-cycle weight ROM, M+2 cycles per node.
// No backpressure; done pulses in the cycle after the last node is stored, results held until next start.
module output_layer_mac
  import output_layer_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   num_inputs,
  input  logic [3:0]   num_nodes,
  input  logic         hidden_we,
  input  logic [3:0]   hidden_addr,
  input  logic [7:0]   hidden_data,
  output logic [7:0]   weight_addr,
  input  logic [7:0]   weight_rdata,
  output logic [127:0] results,
  output logic         busy,
  output logic         done
);

  state_t                  state_q, state_d;
  logic [NODE_W-1:0]       node_q, node_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        idx_p_q, idx_p_d;
  logic                    pv_q, pv_d;
  logic [4:0]              n_q, n_d;
  logic [4:0]              m_q, m_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              waddr_q, waddr_d;
  logic [127:0]            results_q, results_d;
  logic signed [7:0]       hidden_q [16];

  logic signed [15:0]      w_ext, h_ext, prod;
  logic signed [7:0]       sat;

  assign w_ext = {{8{weight_rdata[7]}}, weight_rdata};
  assign h_ext = {{8{hidden_q[idx_p_q][7]}}, hidden_q[idx_p_q]};
  assign prod  = w_ext * h_ext;

  mac_sat_unit #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_sat (
    .acc_i(acc_q),
    .sat_o(sat)
  );

  always_comb begin
    state_d   = state_q;
    node_d    = node_q;
    idx_d     = idx_q;
    idx_p_d   = idx_p_q;
    pv_d      = 1'b0;
    n_d       = n_q;
    m_d       = m_q;
    acc_d     = acc_q;
    waddr_d   = waddr_q;
    results_d = results_q;

    // ROM data for the address issued last cycle is consumed here.
    if (pv_q) begin
      acc_d = acc_q + {{(ACC_W-16){prod[15]}}, prod};
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d       = decode_count(num_nodes);
          m_d       = decode_count(num_inputs);
          node_d    = '0;
          idx_d     = '0;
          results_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        waddr_d = {node_q, idx_q};
        pv_d    = 1'b1;
        idx_p_d = idx_q;
        idx_d   = idx_q + 1'b1;
        if ({1'b0, idx_q} == m_q - 5'd1) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_STORE;
      end
      S_STORE: begin
        results_d[{node_q, 3'b000} +: 8] = sat;
        acc_d = '0;
        if ({1'b0, node_q} == n_q - 5'd1) begin
          state_d = S_DONE;
        end else begin
          node_d  = node_q + 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      node_q    <= '0;
      idx_q     <= '0;
      idx_p_q   <= '0;
      pv_q      <= 1'b0;
      n_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      waddr_q   <= '0;
      results_q <= '0;
    end else begin
      state_q   <= state_d;
      node_q    <= node_d;
      idx_q     <= idx_d;
      idx_p_q   <= idx_p_d;
      pv_q      <= pv_d;
      n_q       <= n_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      waddr_q   <= waddr_d;
      results_q <= results_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        hidden_q[i] <= '0;
      end
    end else if (hidden_we && !busy) begin
      hidden_q[hidden_addr] <= hidden_data;
    end
  end

  // The address is live in RUN so the ROM sees it one cycle before the accumulate edge.
  assign weight_addr = (state_q == S_RUN) ? {node_q, idx_q} : waddr_q;
  assign results     = results_q;
  assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_STORE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_output_layer_mac.sv
// Randomized self-checking bench for output_layer_mac with a dot-product reference model.
module tb_output_layer_mac;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   num_inputs = '0;
  logic [3:0]   num_nodes = '0;
  logic         hidden_we = 1'b0;
  logic [3:0]   hidden_addr = '0;
  logic [7:0]   hidden_data = '0;
  logic [7:0]   weight_addr;
  logic [7:0]   weight_rdata = '0;
  logic [127:0] results;
  logic         busy;
  logic         done;

  logic [7:0]        rom [256];
  logic signed [7:0] hid_m [16];
  int checks = 0;
  int passed = 0;

  output_layer_mac dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_inputs(num_inputs),
    .num_nodes(num_nodes),
    .hidden_we(hidden_we),
    .hidden_addr(hidden_addr),
    .hidden_data(hidden_data),
    .weight_addr(weight_addr),
    .weight_rdata(weight_rdata),
    .results(results),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous weight ROM: data for an address appears one cycle later.
  always @(posedge clk) weight_rdata <= rom[weight_addr];

  function automatic logic [127:0] model(input int n, input int m);
    logic [127:0] res = '0;
    for (int k = 0; k < n; k++) begin
      int s = 0;
      int r;
      for (int i = 0; i < m; i++) begin
        int w = $signed(rom[k*16 + i]);
        int h = hid_m[i];
        s += w * h;
      end
      r = s >>> 7;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      res[k*8 +: 8] = 8'(r);
    end
    return res;
  endfunction

  task automatic write_hidden(input int a, input int d);
    @(negedge clk);
    hidden_we   = 1'b1;
    hidden_addr = 4'(a);
    hidden_data = 8'(d);
    @(negedge clk);
    hidden_we = 1'b0;
    hid_m[a] = 8'(d);
  endtask

  // The DONE cycle is the N*(M+2)+1-th cycle counting the one opened by the start edge,
  // so done is first seen after N*(M+2) further rising edges.
  task automatic run_pass(input int n_enc, input int m_enc, input bit disturb, input string tag);
    int n = (n_enc == 0) ? 16 : n_enc;
    int m = (m_enc == 0) ? 16 : m_enc;
    int lat = n * (m + 2);
    int cnt = 0;
    int extra = 0;
    logic [127:0] exp_res = model(n, m);
    @(negedge clk);
    num_nodes  = 4'(n_enc);
    num_inputs = 4'(m_enc);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start got=%b want=1", tag, busy);
    else passed++;
    while (done !== 1'b1 && cnt < lat + 20) begin
      if (disturb && cnt == 3) begin
        start = 1'b1; hidden_we = 1'b1; hidden_addr = 4'd0; hidden_data = 8'd5;
      end
      if (disturb && cnt == 6) begin
        start = 1'b0; hidden_we = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    hidden_we = 1'b0;
    checks++;
    if (cnt !== lat) $display("FAIL %s done_latency got=%0d want=%0d", tag, cnt, lat);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL %s busy_at_done got=%b want=0", tag, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL %s done_width got=%b want=0", tag, done);
    else passed++;
    checks++;
    if (results !== exp_res) $display("FAIL %s results got=%h want=%h", tag, results, exp_res);
    else passed++;
    if (disturb) begin
      repeat (30) begin
        @(negedge clk);
        if (done === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0) $display("FAIL %s extra_done got=%0d want=0", tag, extra);
      else passed++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) hid_m[i] = '0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (results !== 128'd0) $display("FAIL reset_results got=%h want=0", results);
    else passed++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags got=%b%b want=00", busy, done);
    else passed++;
    checks++;
    if (weight_addr !== 8'd0) $display("FAIL reset_waddr got=%h want=00", weight_addr);
    else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || results !== 128'd0)
      $display("FAIL idle_after_reset got busy=%b done=%b results=%h want 0", busy, done, results);
    else passed++;
  endtask

  task automatic test_single();
    write_hidden(0, 64);
    rom[8'h00] = 8'd64;
    run_pass(1, 1, 1'b0, "single");
    checks++;
    if (results !== 128'd32) $display("FAIL single_const got=%h want=32", results);
    else passed++;
  endtask

  task automatic test_saturate();
    logic [127:0] want_pos = {16{8'h7F}};
    logic [127:0] want_neg = {16{8'h80}};
    for (int i = 0; i < 16; i++) write_hidden(i, 127);
    for (int i = 0; i < 256; i++) rom[i] = 8'd127;
    run_pass(0, 0, 1'b0, "sat_pos");
    checks++;
    if (results !== want_pos) $display("FAIL sat_pos_const got=%h want=%h", results, want_pos);
    else passed++;
    for (int i = 0; i < 256; i++) rom[i] = 8'h80;
    run_pass(0, 0, 1'b0, "sat_neg");
    checks++;
    if (results !== want_neg) $display("FAIL sat_neg_const got=%h want=%h", results, want_neg);
    else passed++;
  endtask

  task automatic test_floor();
    write_hidden(0, -1);
    rom[8'h00] = 8'd1;
    run_pass(1, 1, 1'b0, "floor");
    checks++;
    if (results !== 128'hFF) $display("FAIL floor_const got=%h want=ff", results);
    else passed++;
  endtask

  task automatic test_mixed();
    write_hidden(0, 10);
    write_hidden(1, -20);
    rom[8'h00] = 8'd16;  rom[8'h01] = 8'd16;
    rom[8'h10] = 8'hF0;  rom[8'h11] = 8'd0;
    rom[8'h20] = 8'd0;   rom[8'h21] = 8'd64;
    run_pass(3, 2, 1'b0, "mixed");
    checks++;
    if (results !== 128'hF6FEFE) $display("FAIL mixed_const got=%h want=f6fefe", results);
    else passed++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) write_hidden(i, $urandom_range(0, 255));
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      run_pass($urandom_range(0, 15), $urandom_range(0, 15), 1'b0, $sformatf("random%0d", t));
    end
  endtask

  task automatic test_busy_ignore();
    for (int i = 0; i < 16; i++) write_hidden(i, $urandom_range(0, 255));
    write_hidden(0, -77);
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    run_pass(4, 5, 1'b1, "busy_ignore");
  endtask

  task automatic test_reset_midpass();
    int cnt = 0;
    int seen = 0;
    for (int i = 0; i < 16; i++) write_hidden(i, $urandom_range(0, 255));
    @(negedge clk);
    num_nodes = 4'd4; num_inputs = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(busy === 1'b1 && weight_addr[7:4] == 4'd2) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt >= 100) $display("FAIL rst_mid_reach got=timeout want=node2");
    else passed++;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) hid_m[i] = '0;
    checks++;
    if (results !== 128'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid_state got results=%h busy=%b done=%b want 0", results, busy, done);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL rst_mid_done got=%0d want=0", seen);
    else passed++;
    run_pass(4, 3, 1'b0, "rst_mid_zero_hidden");
    for (int i = 0; i < 4; i++) write_hidden(i, $urandom_range(0, 255));
    run_pass(4, 3, 1'b0, "rst_mid_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_floor();
    test_mixed();
    test_random();
    test_busy_ignore();
    test_reset_midpass();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
